// File: rtl/seq_stage_reg.sv
// Sequence/stage/branch register set feeding the sub-sequence decoder.
// Ports: CLK2/GENRST clock and async active-low reset; WBUS write bus;
//   WSQ/NISQ/ST1/ST2/EOS sequencing pulses; TSGN/TOV/TMZ/TPZG branch
//   tests; RPT_REQ/INHINT interrupt levels; SUBSEQ={SB,SQ,STB} word,
//   RUPT_ACK interrupt-taken pulse, SUBSEQ_NEW word-changed pulse.
module seq_stage_reg #(
    parameter logic [3:0] RUPT_SQ  = 4'b0011,
    parameter logic [1:0] RUPT_STB = 2'b10
) (
    input  logic        CLK2,
    input  logic        GENRST,
    input  logic [15:0] WBUS,
    input  logic        WSQ,
    input  logic        NISQ,
    input  logic        ST1,
    input  logic        ST2,
    input  logic        EOS,
    input  logic        TSGN,
    input  logic        TOV,
    input  logic        TMZ,
    input  logic        TPZG,
    input  logic        RPT_REQ,
    input  logic        INHINT,
    output logic [7:0]  SUBSEQ,
    output logic        RUPT_ACK,
    output logic        SUBSEQ_NEW
);

    logic [3:0] sq;
    logic [1:0] stb;
    logic [1:0] sb;
    logic [3:0] sq_next;
    logic [1:0] pend_stb;
    logic       pend_nisq;

    logic [3:0] sq_eff;
    logic [1:0] pend_eff;
    logic       nisq_eff;
    logic       go_rupt;
    logic       go_new;
    logic       wb_ones;
    logic       wb_zero;
    logic       br2_val;

    // Same-cycle WSQ bypasses the buffer so WSQ+NISQ+EOS works in one cycle.
    assign sq_eff   = WSQ ? WBUS[15:12] : sq_next;
    assign pend_eff = pend_stb | {ST2, ST1};
    assign nisq_eff = pend_nisq | NISQ;
    assign go_rupt  = nisq_eff & RPT_REQ & ~INHINT;
    assign go_new   = nisq_eff & ~go_rupt;

    assign wb_ones = &WBUS;
    assign wb_zero = ~|WBUS;
    assign br2_val = (TMZ & wb_ones) | (TPZG & wb_zero);

    assign SUBSEQ = {sb, sq, stb};

    always_ff @(posedge CLK2 or negedge GENRST) begin
        if (!GENRST) begin
            sq         <= 4'h0;
            stb        <= 2'b00;
            sq_next    <= 4'h0;
            pend_stb   <= 2'b00;
            pend_nisq  <= 1'b0;
            RUPT_ACK   <= 1'b0;
            SUBSEQ_NEW <= 1'b0;
        end else begin
            RUPT_ACK   <= EOS & go_rupt;
            SUBSEQ_NEW <= EOS;
            if (WSQ)
                sq_next <= WBUS[15:12];
            if (EOS) begin
                pend_stb  <= 2'b00;
                pend_nisq <= 1'b0;
                unique case (1'b1)
                    go_rupt: begin
                        sq  <= RUPT_SQ;
                        stb <= RUPT_STB;
                    end
                    go_new: begin
                        sq  <= sq_eff;
                        stb <= 2'b00;
                    end
                    default: stb <= pend_eff;
                endcase
            end else begin
                pend_stb  <= pend_eff;
                pend_nisq <= nisq_eff;
            end
        end
    end

    // Branch pair; TOV classifies sign/guard bits and wins over other tests.
    always_ff @(posedge CLK2 or negedge GENRST) begin
        if (!GENRST) begin
            sb <= 2'b00;
        end else if (TOV) begin
            unique case (WBUS[15:14])
                2'b01:   sb <= 2'b01;
                2'b10:   sb <= 2'b10;
                default: sb <= 2'b00;
            endcase
        end else begin
            if (TSGN)
                sb[0] <= WBUS[15];
            if (TMZ | TPZG)
                sb[1] <= br2_val;
        end
    end

endmodule

// File: tb/tb_seq_stage_reg.sv
// Testbench for seq_stage_reg: directed plan steps plus random traffic.
// Compares DUT outputs each cycle against a behavioural reference model.
module tb_seq_stage_reg;

    logic        CLK2 = 1'b0;
    logic        GENRST;
    logic [15:0] WBUS;
    logic        WSQ, NISQ, ST1, ST2, EOS;
    logic        TSGN, TOV, TMZ, TPZG;
    logic        RPT_REQ, INHINT;
    logic [7:0]  SUBSEQ;
    logic        RUPT_ACK, SUBSEQ_NEW;

    int checks = 0;
    int errors = 0;

    // reference state
    int m_sq, m_stb, m_sb, m_sqn, m_pst;
    bit m_pn, m_ack, m_new;

    seq_stage_reg dut (
        .CLK2(CLK2), .GENRST(GENRST), .WBUS(WBUS),
        .WSQ(WSQ), .NISQ(NISQ), .ST1(ST1), .ST2(ST2), .EOS(EOS),
        .TSGN(TSGN), .TOV(TOV), .TMZ(TMZ), .TPZG(TPZG),
        .RPT_REQ(RPT_REQ), .INHINT(INHINT),
        .SUBSEQ(SUBSEQ), .RUPT_ACK(RUPT_ACK), .SUBSEQ_NEW(SUBSEQ_NEW)
    );

    always #5 CLK2 = ~CLK2;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sq = 0; m_stb = 0; m_sb = 0; m_sqn = 0;
        m_pst = 0; m_pn = 0; m_ack = 0; m_new = 0;
    endtask

    function automatic int model_word();
        return m_sb * 64 + m_sq * 4 + m_stb;
    endfunction

    // One clock of the spec's rules, using the inputs now on the pins.
    task automatic model_step();
        int  sqe, pend, hi;
        bit  ni;
        sqe  = WSQ ? int'(WBUS >> 12) : m_sqn;
        pend = m_pst | (int'(ST2) * 2 + int'(ST1));
        ni   = m_pn | NISQ;
        m_ack = 0;
        m_new = 0;
        if (EOS) begin
            m_new = 1;
            if (ni && RPT_REQ && !INHINT) begin
                m_sq = 3; m_stb = 2; m_ack = 1;
            end else if (ni) begin
                m_sq = sqe; m_stb = 0;
            end else begin
                m_stb = pend;
            end
            m_pst = 0; m_pn = 0;
        end else begin
            m_pst = pend;
            m_pn  = ni;
        end
        if (WSQ) m_sqn = int'(WBUS >> 12);
        if (TOV) begin
            hi = int'(WBUS >> 14);
            // sign clear + guard set = positive overflow; reverse = negative
            m_sb = (hi == 1) ? 1 : (hi == 2) ? 2 : 0;
        end else begin
            if (TSGN) m_sb = (m_sb & 2) | int'(WBUS[15]);
            if (TMZ || TPZG)
                m_sb = (m_sb & 1) |
                       (((TMZ && WBUS == 16'hFFFF) ||
                         (TPZG && WBUS == 16'h0000)) ? 2 : 0);
        end
    endtask

    task automatic idle_pulses();
        WSQ = 0; NISQ = 0; ST1 = 0; ST2 = 0; EOS = 0;
        TSGN = 0; TOV = 0; TMZ = 0; TPZG = 0;
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge CLK2);
        #1;
        chk({tag, ".subseq"}, SUBSEQ, model_word());
        chk({tag, ".ack"}, RUPT_ACK, m_ack);
        chk({tag, ".new"}, SUBSEQ_NEW, m_new);
        idle_pulses();
    endtask

    task automatic do_reset(input string tag);
        GENRST = 0;
        model_reset();
        #1;
        chk({tag, ".rst_word"}, SUBSEQ, 0);
        chk({tag, ".rst_ack"}, RUPT_ACK, 0);
        chk({tag, ".rst_new"}, SUBSEQ_NEW, 0);
        @(posedge CLK2);
        #1;
        GENRST = 1;
    endtask

    initial begin
        int r;
        GENRST = 0; WBUS = 0; RPT_REQ = 0; INHINT = 0;
        idle_pulses();
        model_reset();
        repeat (2) @(posedge CLK2);
        #1 GENRST = 1;

        // 1: some activity, then reset mid-subsequence
        WBUS = 16'h7000; WSQ = 1; step("pre");
        ST1 = 1; NISQ = 1; step("pre2");
        do_reset("t1");
        EOS = 1; step("t1_noupd");
        chk("t1_nochange", SUBSEQ, 8'h00);
        WBUS = 16'hE000; WSQ = 1; step("t1_wsq");
        WBUS = 0; NISQ = 1; step("t1_nisq");
        step("t1_gap");
        EOS = 1; step("t1_eos");
        chk("t1_load", SUBSEQ, 8'b00_1110_00);
        chk("t1_newpulse", SUBSEQ_NEW, 1);
        step("t1_after");
        chk("t1_newdrop", SUBSEQ_NEW, 0);

        // 2: stage advance
        WBUS = 16'h1000; WSQ = 1; NISQ = 1; EOS = 1; step("t2_ld");
        ST1 = 1; step("t2_st1");
        EOS = 1; step("t2_eos1");
        chk("t2_ccs1", SUBSEQ, 8'b00_0001_01);
        EOS = 1; step("t2_eos2");
        chk("t2_stb0", SUBSEQ, 8'b00_0001_00);
        ST1 = 1; ST2 = 1; EOS = 1; step("t2_eos3");
        chk("t2_stb3", SUBSEQ, 8'b00_0001_11);

        // 3: interrupt entry, then inhibited
        WBUS = 16'h5000; WSQ = 1; step("t3_wsq");
        RPT_REQ = 1; NISQ = 1; EOS = 1; step("t3_rupt");
        chk("t3_rupt1", SUBSEQ, 8'b00_0011_10);
        chk("t3_ack", RUPT_ACK, 1);
        step("t3_ackdrop");
        chk("t3_ack0", RUPT_ACK, 0);
        INHINT = 1; NISQ = 1; EOS = 1; step("t3_inh");
        chk("t3_inhword", SUBSEQ, 8'b00_0101_00);
        chk("t3_noack", RUPT_ACK, 0);
        RPT_REQ = 0; INHINT = 0;

        // 4: overflow test
        WBUS = 16'h4000; TOV = 1; step("t4_pinc");
        chk("t4_sb01", SUBSEQ[7:6], 1);
        WBUS = 16'h8000; TOV = 1; step("t4_minc");
        chk("t4_sb10", SUBSEQ[7:6], 2);
        WBUS = 16'hC000; TOV = 1; step("t4_none");
        chk("t4_sb00", SUBSEQ[7:6], 0);
        WBUS = 16'h4000; TOV = 1; TSGN = 1; step("t4_ovr");
        chk("t4_tovwins", SUBSEQ[7:6], 1);

        // 5: zero tests, persistence across EOS
        WBUS = 16'h0000; TPZG = 1; step("t5_pz");
        chk("t5_br2", SUBSEQ[7], 1);
        WBUS = 16'h7FFF; TMZ = 1; step("t5_mz");
        chk("t5_br2z", SUBSEQ[7], 0);
        WBUS = 16'hFFFF; TSGN = 1; TMZ = 1; step("t5_both");
        chk("t5_sb11", SUBSEQ[7:6], 3);
        NISQ = 1; EOS = 1; step("t5_eos");
        chk("t5_keep", SUBSEQ[7:6], 3);

        // 6: same-cycle bypass
        WBUS = 16'h9000; WSQ = 1; NISQ = 1; EOS = 1; step("t6_byp");
        chk("t6_word", SUBSEQ[5:0], 6'b1001_00);
        WBUS = 16'h2000; WSQ = 1; step("t6_wsq");
        EOS = 1; step("t6_eos");
        chk("t6_hold", SUBSEQ[5:2], 4'b1001);
        NISQ = 1; EOS = 1; step("t6_take");
        chk("t6_new", SUBSEQ[5:2], 4'b0010);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 4);
            case (r)
                0: WBUS = 16'h0000;
                1: WBUS = 16'hFFFF;
                2: WBUS = 16'h4000;
                3: WBUS = 16'h8000;
                default: WBUS = 16'($urandom);
            endcase
            WSQ  = ($urandom_range(0, 5) == 0);
            NISQ = ($urandom_range(0, 4) == 0);
            ST1  = ($urandom_range(0, 4) == 0);
            ST2  = ($urandom_range(0, 4) == 0);
            EOS  = ($urandom_range(0, 3) == 0);
            TSGN = ($urandom_range(0, 4) == 0);
            TOV  = ($urandom_range(0, 5) == 0);
            TMZ  = ($urandom_range(0, 4) == 0);
            TPZG = ($urandom_range(0, 4) == 0);
            RPT_REQ = ($urandom_range(0, 2) == 0);
            INHINT  = ($urandom_range(0, 3) == 0);
            if (i == 200) begin
                idle_pulses();
                do_reset("rnd_rst");
            end else begin
                step("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
